// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter slice.
package uart_arb_pkg;

   localparam int ARB_DATA_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: chooses the first set request bit
// searching upward from rr_ptr+1, wrapping modulo N. Reusable on the RX side.
module uart_rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] rr_ptr,
   output logic [N-1:0]         pick,
   output logic                 any
);

   localparam int PW = $clog2(N);

   logic [PW:0]   slot;
   logic [PW-1:0] idx;
   logic          found;

   // Walk the N candidate slots after rr_ptr and keep the first requester seen
   always_comb begin
      pick  = '0;
      found = 1'b0;
      slot  = '0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         slot = {1'b0, rr_ptr} + (PW+1)'(k);
         if (slot >= (PW+1)'(N)) begin
            slot = slot - (PW+1)'(N);
         end
         idx = slot[PW-1:0];
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX byte interface
// between NREQ requesters. Optional forced release of a stalled lock is
// enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*ARB_DATA_W-1:0] req_data,
   input  logic [NREQ-1:0]            req_last,
   output logic [NREQ-1:0]            req_ready,
   output logic                       tx_valid,
   output logic [ARB_DATA_W-1:0]      tx_data,
   input  logic                       tx_ready,
   output logic [NREQ-1:0]            grant,
   output logic                       timeout_pulse
);

   localparam int PW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
      $error("uart_tx_arbiter: NREQ must be within 2..16");
   end
   if (LOCK_TIMEOUT < 2) begin : g_bad_timeout
      $error("uart_tx_arbiter: LOCK_TIMEOUT must be at least 2");
   end

   arb_state_t      state;
   arb_state_t      state_nxt;
   logic [NREQ-1:0] grant_nxt;
   logic [NREQ-1:0] pick;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   rr_ptr_nxt;
   logic [PW-1:0]   owner_idx;
   logic            any_req;
   logic            owner_valid;
   logic            owner_last;
   logic            handshake;
   logic            force_release;

   uart_rr_pick #(.N(NREQ)) u_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr),
      .pick   (pick),
      .any    (any_req)
   );

   // Turn the one-hot grant into the owner index used as the next rr pointer
   always_comb begin
      owner_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            owner_idx = PW'(i);
         end
      end
   end

   // Route the owner's byte straight through; grant is zero outside LOCK
   always_comb begin
      tx_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            tx_data = tx_data | req_data[i*ARB_DATA_W +: ARB_DATA_W];
         end
      end
   end

   assign owner_valid = |(req_valid & grant);
   assign owner_last  = |(req_last & grant);
   assign tx_valid    = (state == LOCK) && owner_valid;
   assign req_ready   = ((state == LOCK) && tx_ready) ? grant : '0;
   assign handshake   = tx_valid && tx_ready;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(LOCK_TIMEOUT);

   logic [CW-1:0] idle_cnt;
   logic          timeout_q;

   assign force_release = (state == LOCK) && !owner_valid &&
                          (idle_cnt == CW'(LOCK_TIMEOUT - 1));
   assign timeout_pulse = timeout_q;

   // Count owner-idle cycles inside a lock; held at zero outside LOCK so entry starts clean
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (state != LOCK || handshake) begin
         idle_cnt <= '0;
      end else if (!owner_valid) begin
         idle_cnt <= idle_cnt + CW'(1);
      end
   end

   // Registered one-cycle pulse marking a forced release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= force_release;
      end
   end
`else
   assign force_release = 1'b0;
   assign timeout_pulse = 1'b0;
`endif

   // Arbitration state, current grant and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= PW'(NREQ - 1);
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

   // Grant for one cycle in IDLE, then hold the lock until the packet ends or is forced out
   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
      rr_ptr_nxt = rr_ptr;
      case (state)
         IDLE: begin
            if (any_req) begin
               grant_nxt = pick;
               state_nxt = LOCK;
            end
         end
         LOCK: begin
            if ((handshake && owner_last) || force_release) begin
               grant_nxt  = '0;
               rr_ptr_nxt = owner_idx;
               state_nxt  = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a random
// phase, all compared against a queue-based behavioural model of the arbiter.
module tb_uart_tx_arbiter;

   localparam int NREQ  = 4;
   localparam int DEPTH = 64;
`ifdef UART_ARB_TIMEOUT_EN
   localparam int LT = 16;
`else
   localparam int LT = 1024;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*8-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic              tx_valid;
   logic [7:0]        tx_data;
   logic              tx_ready;
   logic [NREQ-1:0]   grant;
   logic              timeout_pulse;

   uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LT)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready),
      .grant         (grant),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   // Requester agents: per-requester byte FIFOs of {last, data}
   logic [8:0] mem [NREQ][DEPTH];
   int         head [NREQ];
   int         tail [NREQ];
   bit         hold [NREQ];
   int         validPct  = 100;
   int         readyMode = 0;
   int         stallLo   = 0;
   int         stallHi   = 0;
   int         cycleNo   = 0;

   // Reference model: owner (-1 when idle), last owner, idle counter, expected pulse
   int              mOwner;
   int              mLastPtr;
   int              mIdle;
   bit              mPulse;
   logic [NREQ-1:0] prevGrant;
   int              dutLog[$];
   int              pulseCount;

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycleNo);
      end
   endtask

   task automatic pushByte(input int r, input logic [7:0] d, input bit last);
      mem[r][tail[r] % DEPTH] = {last, d};
      tail[r]++;
   endtask

   task automatic pushPacket(input int r, input int len);
      for (int k = 0; k < len; k++) begin
         pushByte(r, 8'($urandom), (k == len - 1));
      end
   endtask

   task automatic applyStimulus();
      logic [8:0] e;
      bit         v;
      for (int i = 0; i < NREQ; i++) begin
         if (hold[i]) v = 1'b1;
         else         v = (head[i] < tail[i]) && ($urandom_range(99) < validPct);
         hold[i] = v;
         e = mem[i][head[i] % DEPTH];
         req_valid[i]      = v;
         req_data[i*8 +: 8] = v ? e[7:0] : 8'h00;
         req_last[i]       = v ? e[8] : 1'b0;
      end
      case (readyMode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ($urandom_range(99) < 60);
         default: tx_ready = !(cycleNo >= stallLo && cycleNo < stallHi);
      endcase
   endtask

   task automatic stepCycle();
      logic [31:0] expGrant;
      logic [31:0] expReady;
      logic [8:0]  e;
      logic        expValid;
      int          o;
      int          c;
      int          gi;
      bit          found;
      @(negedge clk);
      o = mOwner;
      expGrant = 32'd0;
      expReady = 32'd0;
      expValid = 1'b0;
      if (o >= 0) begin
         expGrant = 32'd1 << o;
         expValid = req_valid[o];
         if (tx_ready) expReady = 32'd1 << o;
      end
      checkOutput("grant", 32'(grant), expGrant);
      checkOutput("tx_valid", 32'(tx_valid), 32'(expValid));
      checkOutput("req_ready", 32'(req_ready), expReady);
      checkOutput("timeout_pulse", 32'(timeout_pulse), 32'(mPulse));
      if (expValid) begin
         e = mem[o][head[o] % DEPTH];
         checkOutput("tx_data", 32'(tx_data), 32'(e[7:0]));
      end
      if (timeout_pulse) pulseCount++;
      if (grant != '0 && grant != prevGrant) begin
         gi = 99;
         for (int i = 0; i < NREQ; i++) begin
            if (grant == NREQ'(1 << i)) gi = i;
         end
         dutLog.push_back(gi);
      end
      prevGrant = grant;
      mPulse = 1'b0;
      if (o < 0) begin
         found = 1'b0;
         for (int k = 1; k <= NREQ; k++) begin
            c = (mLastPtr + k) % NREQ;
            if (!found && req_valid[c]) begin
               found  = 1'b1;
               mOwner = c;
               mIdle  = 0;
            end
         end
      end else if (req_valid[o] && tx_ready) begin
         e = mem[o][head[o] % DEPTH];
         head[o]++;
         hold[o] = 1'b0;
         mIdle   = 0;
         if (e[8]) begin
            mLastPtr = o;
            mOwner   = -1;
         end
      end else if (!req_valid[o]) begin
`ifdef UART_ARB_TIMEOUT_EN
         if (mIdle == LT - 1) begin
            mPulse   = 1'b1;
            mLastPtr = o;
            mOwner   = -1;
            mIdle    = 0;
         end else begin
            mIdle++;
         end
`endif
      end
      @(posedge clk);
      #1;
      cycleNo++;
      applyStimulus();
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   task automatic applyReset();
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         head[i] = 0;
         tail[i] = 0;
         hold[i] = 1'b0;
      end
      mOwner    = -1;
      mLastPtr  = NREQ - 1;
      mIdle     = 0;
      mPulse    = 1'b0;
      prevGrant = '0;
      applyStimulus();
      #1;
      checkOutput("rst_grant", 32'(grant), 32'd0);
      checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
      checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycleNo++;
      applyStimulus();
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_data   = '0;
      req_last   = '0;
      tx_ready   = 1'b0;
      pulseCount = 0;
      for (int i = 0; i < NREQ; i++) begin
         head[i] = 0;
         tail[i] = 0;
         hold[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      applyReset();

      // Single requester, three-byte packet with no back-pressure
      $display("[TB] single requester packet");
      dutLog.delete();
      pushByte(1, 8'hA5, 1'b0);
      pushByte(1, 8'h5A, 1'b0);
      pushByte(1, 8'hFF, 1'b1);
      applyStimulus();
      runCycles(8);
      checkOutput("t1_grant_count", 32'(dutLog.size()), 32'd1);
      if (dutLog.size() > 0) checkOutput("t1_owner", 32'(dutLog[0]), 32'd1);
      checkOutput("t1_grant_released", 32'(grant), 32'd0);

      // Two requesters from reset, no interleaving
      $display("[TB] two requesters from reset");
      applyReset();
      dutLog.delete();
      pushPacket(0, 2);
      pushPacket(2, 2);
      applyStimulus();
      runCycles(10);
      checkOutput("t2_grant_count", 32'(dutLog.size()), 32'd2);
      if (dutLog.size() > 1) begin
         checkOutput("t2_first", 32'(dutLog[0]), 32'd0);
         checkOutput("t2_second", 32'(dutLog[1]), 32'd2);
      end

      // Fairness with all requesters streaming single-byte packets
      $display("[TB] round-robin fairness");
      applyReset();
      dutLog.delete();
      for (int p = 0; p < 2; p++) begin
         for (int r = 0; r < NREQ; r++) pushByte(r, 8'($urandom), 1'b1);
      end
      applyStimulus();
      runCycles(20);
      checkOutput("t3_grant_count", 32'(dutLog.size()), 32'd8);
      for (int i = 0; i < dutLog.size() && i < 8; i++) begin
         checkOutput("t3_order", 32'(dutLog[i]), 32'(i % NREQ));
      end

      // Back-pressure for five cycles in the middle of a packet
      $display("[TB] mid-packet back-pressure");
      readyMode = 2;
      pushPacket(3, 4);
      stallLo = cycleNo + 3;
      stallHi = stallLo + 5;
      applyStimulus();
      runCycles(16);
      readyMode = 0;
      checkOutput("t4_drained", 32'(head[3]), 32'(tail[3]));

      // Owner stalls mid-packet while another requester waits
      $display("[TB] stalled lock");
      dutLog.delete();
      pulseCount = 0;
      pushByte(1, 8'h11, 1'b0);
      applyStimulus();
      runCycles(3);
      pushPacket(2, 2);
      runCycles(130);
`ifdef UART_ARB_TIMEOUT_EN
      checkOutput("t5_pulses", 32'(pulseCount), 32'd1);
      checkOutput("t5_grant_count", 32'(dutLog.size()), 32'd2);
      if (dutLog.size() > 1) checkOutput("t5_next_owner", 32'(dutLog[1]), 32'd2);
`else
      checkOutput("t5_pulses", 32'(pulseCount), 32'd0);
      checkOutput("t5_lock_held", 32'(grant), 32'b0010);
      checkOutput("t5_grant_count", 32'(dutLog.size()), 32'd1);
`endif
      pushByte(1, 8'h22, 1'b1);
      runCycles(12);
      checkOutput("t5_all_sent", 32'(head[2]), 32'(tail[2]));

      // Reset in the middle of a packet
      $display("[TB] reset mid-packet");
      pushPacket(2, 6);
      applyStimulus();
      runCycles(3);
      applyReset();
      dutLog.delete();
      pushPacket(2, 2);
      pushPacket(0, 2);
      applyStimulus();
      runCycles(10);
      if (dutLog.size() > 0) checkOutput("t6_first_owner", 32'(dutLog[0]), 32'd0);
      else checkOutput("t6_grant_count", 32'(dutLog.size()), 32'd2);

      // Randomised traffic against the model
      $display("[TB] random traffic");
      applyReset();
      validPct  = 70;
      readyMode = 1;
      for (int n = 0; n < 1500; n++) begin
         for (int r = 0; r < NREQ; r++) begin
            if ((tail[r] - head[r]) < 4 && $urandom_range(3) == 0) begin
               pushPacket(r, $urandom_range(1, 5));
            end
         end
         stepCycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between NREQ byte-stream requesters (command responder, debug printer, loopback, ...). Grants are round-robin and locked per packet, so a multi-byte message is never interleaved with another requester's bytes. Sits between the requesters and the UART TX byte interface, in the same clk domain as the UART core.

Parameters:
NREQ, 4, number of requesters (2..16)
LOCK_TIMEOUT, 1024, idle cycles tolerated inside a locked packet before forced release (only with UART_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester byte valid
req_data  input  NREQ*8  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  NREQ  byte is the final byte of the packet
req_ready  output  NREQ  byte accepted this cycle
tx_valid  output  1  byte offered to UART TX
tx_data  output  8  byte to UART TX
tx_ready  input  1  UART TX accepts byte (handshake = tx_valid & tx_ready)
grant  output  NREQ  one-hot current owner; all zero when idle
timeout_pulse  output  1  one-cycle pulse on forced release

Behaviour:
- Reset (async assert, sync release): state IDLE, grant 0, req_ready 0, tx_valid 0, tx_data 0, timeout_pulse 0, rr pointer = NREQ-1 (requester 0 wins first).
- States: IDLE, LOCK.
- IDLE: tx_valid=0, req_ready=0. If any req_valid is set, pick the first set bit searching from rr_ptr+1 upward, wrapping modulo NREQ. Register the grant and go to LOCK. Arbitration costs exactly 1 cycle; no byte moves in IDLE.
- LOCK, owner g: tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready, all other req_ready=0. These are combinational pass-through: zero added latency per byte, and the owner sees back-pressure directly.
- Handshake with req_last[g]=1: rr_ptr<=g, grant<=0, go to IDLE. The next packet from anyone starts after the 1 IDLE cycle.
- Handshake with req_last[g]=0: stay in LOCK. Requests from other requesters are ignored until release.
- tx_ready is ignored in IDLE. A requester dropping req_valid mid-packet keeps the lock (see optional feature).
- A single-byte packet (valid & last on the first byte) takes 1 cycle in IDLE, then 1+ cycles in LOCK.
- Fairness: with all NREQ requesters continuously requesting single-byte packets, the grant order is 0,1,...,NREQ-1,0,...
- Async reset mid-packet: return to reset values immediately; the partial packet is abandoned and the requester must resend.
- tx_data is held stable while tx_valid=1 and tx_ready=0, provided the owner obeys valid/data stability.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined: in LOCK a counter of width $clog2(LOCK_TIMEOUT) counts cycles with req_valid[g]=0. It clears on every handshake and on entering LOCK. When it reaches LOCK_TIMEOUT-1: go to IDLE, rr_ptr<=g, timeout_pulse=1 for one cycle, no byte is lost.
- Undefined: no counter, timeout_pulse tied to 0, the lock is held until req_last.

Decomposition:
- uart_arb_pkg: state enum (IDLE, LOCK) and the ARB_DATA_W=8 constant.
- Sub-module uart_rr_pick: combinational round-robin picker with inputs req, rr_ptr and outputs one-hot pick and any. It is reusable for a future RX-side demux arbiter.

Test Plan:
- Single requester 1 sends 3 bytes A5,5A,FF (last on FF), tx_ready=1: grant=0010 one cycle after req_valid. Bytes appear on tx_data on 3 consecutive cycles. grant returns to 0 after FF.
- Requesters 0 and 2 both valid from reset, 2-byte packets each: requester 0's bytes both precede requester 2's (no interleave). Requester 2 is granted after 1 IDLE cycle.
- All 4 requesters continuously send single-byte packets: the grant sequence over 8 packets is 0,1,2,3,0,1,2,3.
- tx_ready low for 5 cycles mid-packet: tx_valid stays 1, tx_data is unchanged, req_ready[g]=0. Exactly one handshake occurs when tx_ready rises.
- UART_ARB_TIMEOUT_EN, LOCK_TIMEOUT=16, owner stalls after byte 1 without last: timeout_pulse fires 16 cycles after the last handshake. The next waiting requester is granted one cycle later. Without the macro, the lock persists for 100+ cycles.
- Assert rst for 1 cycle mid-packet: all outputs are 0 immediately. After release, requester 0 wins the first arbitration.
